// File: rtl/apb_devinfo_reader.sv
`default_nettype none
// ============================================================================
// Module   : apb_devinfo_reader
// Purpose  : APB requester that polls the device-information completer until
//            IDCODE and die serial are valid. It then reads IDCODE, the 64-bit
//            serial and USERCODE, and holds them as stable parallel outputs.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            refresh            - pulse in DONE/ERROR restarts the sequence
//            psel .. pslverr    - APB requester interface
//            idcode, die_serial,
//            usercode           - captured fields, updated as each read lands
//            info_valid, busy,
//            error, error_code  - sequence status (code 1 slverr, 2 poll
//                                 timeout, 3 self-test mismatch)
// Options  : DEVINFO_READER_SELFTEST_EN - writes and reads back SCRATCH
//            before the STATUS poll
// Revision : 1.0 - initial release
// ============================================================================
module apb_devinfo_reader #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter int unsigned MAX_POLLS     = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refresh,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [31:0]           pwdata,
    input  logic                  pready,
    input  logic [31:0]           prdata,
    input  logic                  pslverr,
    output logic [31:0]           idcode,
    output logic [63:0]           die_serial,
    output logic [31:0]           usercode,
    output logic                  info_valid,
    output logic                  busy,
    output logic                  error,
    output logic [1:0]            error_code
);

    typedef enum logic [2:0] {
        START     = 3'd0,
        SETUP     = 3'd1,
        ACCESS    = 3'd2,
        POLL_WAIT = 3'd3,
        DONE      = 3'd4,
        ERROR     = 3'd5
    } state_t;

    // Step index: which register the next transfer targets.
    localparam logic [2:0] c_step_status = 3'd0;
    localparam logic [2:0] c_step_idcode = 3'd1;
    localparam logic [2:0] c_step_ser0   = 3'd2;
    localparam logic [2:0] c_step_ser1   = 3'd3;
    localparam logic [2:0] c_step_user   = 3'd4;
    localparam logic [2:0] c_step_scr_wr = 3'd5;
    localparam logic [2:0] c_step_scr_rd = 3'd6;

`ifdef DEVINFO_READER_SELFTEST_EN
    localparam logic [2:0] c_first_step = c_step_scr_wr;
`else
    localparam logic [2:0] c_first_step = c_step_status;
`endif

    localparam logic [31:0]           c_scratch_pattern = 32'hA5A5_5A5A;
    localparam logic [ADDR_WIDTH-1:0] c_base            = ADDR_WIDTH'(BASE_ADDR);

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_step;
    logic [2:0]            w_step_next;
    logic [15:0]           r_poll_cnt;
    logic [15:0]           w_poll_inc;
    logic [31:0]           r_wait_cnt;
    logic [31:0]           r_idcode;
    logic [63:0]           r_serial;
    logic [31:0]           r_usercode;
    logic [1:0]            r_error_code;
    logic [1:0]            w_err_code;
    logic [7:0]            w_offset;
    logic [ADDR_WIDTH-1:0] w_step_addr;
    logic                  w_status_ok;
    logic                  w_poll_timeout;
    logic                  w_xfer_ok;
    logic                  w_idle_state;

    // ---------------------------------------------------------------- decode
    always_comb begin
        w_offset = 8'h00;
        case (r_step)
            c_step_status: w_offset = 8'h00;
            c_step_idcode: w_offset = 8'h04;
            c_step_ser0:   w_offset = 8'h0c;
            c_step_ser1:   w_offset = 8'h10;
            c_step_user:   w_offset = 8'h14;
            c_step_scr_wr,
            c_step_scr_rd: w_offset = 8'h18;
            default:       w_offset = 8'h00;
        endcase
    end

    always_comb begin
        w_step_next = c_step_status;
        case (r_step)
            c_step_status: w_step_next = c_step_idcode;
            c_step_idcode: w_step_next = c_step_ser0;
            c_step_ser0:   w_step_next = c_step_ser1;
            c_step_ser1:   w_step_next = c_step_user;
            c_step_scr_wr: w_step_next = c_step_scr_rd;
            c_step_scr_rd: w_step_next = c_step_status;
            default:       w_step_next = c_step_status;
        endcase
    end

    assign w_step_addr    = c_base + ADDR_WIDTH'(w_offset);
    assign w_status_ok    = (prdata[1:0] == 2'b11);
    // Saturating so a huge MAX_POLLS can never wrap back below the limit.
    assign w_poll_inc     = (r_poll_cnt == 16'hFFFF) ? r_poll_cnt : r_poll_cnt + 16'd1;
    assign w_poll_timeout = (32'(w_poll_inc) >= MAX_POLLS);
    assign w_xfer_ok      = (r_state == ACCESS) && pready && !pslverr;
    assign w_idle_state   = (r_state == DONE) || (r_state == ERROR);

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= START;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_code   = 2'd0;
        psel         = 1'b0;
        penable      = 1'b0;
        paddr        = '0;
        case (r_state)
            // START is also the mandatory idle cycle between transfers.
            START: w_state_next = SETUP;
            SETUP: begin
                psel         = 1'b1;
                paddr        = w_step_addr;
                w_state_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                paddr   = w_step_addr;
                if (pready) begin
                    if (pslverr) begin
                        w_state_next = ERROR;
                        w_err_code   = 2'd1;
                    end else begin
                        case (r_step)
                            c_step_status: begin
                                if (w_status_ok) begin
                                    w_state_next = START;
                                end else if (w_poll_timeout) begin
                                    w_state_next = ERROR;
                                    w_err_code   = 2'd2;
                                end else begin
                                    w_state_next = POLL_WAIT;
                                end
                            end
                            c_step_user: w_state_next = DONE;
                            c_step_scr_rd: begin
                                if (prdata != c_scratch_pattern) begin
                                    w_state_next = ERROR;
                                    w_err_code   = 2'd3;
                                end else begin
                                    w_state_next = START;
                                end
                            end
                            default: w_state_next = START;
                        endcase
                    end
                end
            end
            POLL_WAIT: begin
                if (r_wait_cnt >= POLL_INTERVAL - 1) begin
                    w_state_next = SETUP;
                end
            end
            DONE, ERROR: begin
                if (refresh) begin
                    w_state_next = START;
                end
            end
            default: w_state_next = START;
        endcase
    end

`ifdef DEVINFO_READER_SELFTEST_EN
    assign pwrite = psel && (r_step == c_step_scr_wr);
    assign pwdata = pwrite ? c_scratch_pattern : 32'h0;
`else
    assign pwrite = 1'b0;
    assign pwdata = 32'h0;
`endif

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step       <= c_first_step;
            r_poll_cnt   <= 16'd0;
            r_wait_cnt   <= 32'd0;
            r_idcode     <= 32'h0;
            r_serial     <= 64'h0;
            r_usercode   <= 32'h0;
            r_error_code <= 2'd0;
        end else begin
            r_wait_cnt <= (r_state == POLL_WAIT) ? r_wait_cnt + 32'd1 : 32'd0;
            if (w_xfer_ok) begin
                case (r_step)
                    c_step_idcode: r_idcode         <= prdata;
                    c_step_ser0:   r_serial[63:32]  <= prdata;
                    c_step_ser1:   r_serial[31:0]   <= prdata;
                    c_step_user:   r_usercode       <= prdata;
                    default:       ;
                endcase
                // A not-ready STATUS keeps the step and counts the poll.
                if ((r_step == c_step_status) && !w_status_ok) begin
                    r_poll_cnt <= w_poll_inc;
                end else begin
                    r_step <= w_step_next;
                end
            end
            if ((w_state_next == ERROR) && (r_state != ERROR)) begin
                r_error_code <= w_err_code;
            end
            if (w_idle_state && refresh) begin
                r_step       <= c_first_step;
                r_poll_cnt   <= 16'd0;
                r_error_code <= 2'd0;
            end
        end
    end

    assign idcode     = r_idcode;
    assign die_serial = r_serial;
    assign usercode   = r_usercode;
    assign error_code = r_error_code;
    assign info_valid = (r_state == DONE);
    assign error      = (r_state == ERROR);
    assign busy       = !w_idle_state;

endmodule
`default_nettype wire

// File: tb/tb_apb_devinfo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_devinfo_reader
// Purpose  : Bench for apb_devinfo_reader with an APB completer model and a
//            behavioural model of the expected transfers and captured fields.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_devinfo_reader;

    localparam int POLL_INTERVAL = 4;
    localparam int MAX_POLLS     = 8;
    localparam int MAX_POLLS_B   = 3;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    logic        clk;
    logic        rst;
    logic        refresh;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [31:0] idcode, usercode;
    logic [63:0] die_serial;
    logic        info_valid, busy, error;
    logic [1:0]  error_code;

    // second instance: STATUS stuck at 0, small poll limit
    logic        b_psel, b_penable, b_pwrite, b_pready;
    logic [7:0]  b_paddr;
    logic [31:0] b_pwdata, b_idcode, b_usercode;
    logic [63:0] b_die_serial;
    logic        b_info_valid, b_busy, b_error;
    logic [1:0]  b_error_code;
    int          b_reads;

    int vectors     = 0;
    int miscompares = 0;

    // completer register contents and behaviour knobs
    logic [31:0] reg_idcode, reg_ser0, reg_ser1, reg_user, reg_scratch;
    logic [1:0]  bad_status;
    int          bad_limit;
    int          status_seen;
    int          wait_states;
    int          err_addr;
    int          acc_cnt;

    // expectations and model state
    xfer_t       exp_arr [256];
    int          exp_wr = 0;
    int          exp_rd = 0;
    logic [31:0] m_idcode, m_user;
    logic [63:0] m_serial;
    int          mstate;   // 0 running, 1 done, 2 error
    logic [1:0]  mcode;
    int          mpolls;
    int          idle = 100;
    bit          last_bad = 0;
    bit          checking = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    apb_devinfo_reader #(
        .ADDR_WIDTH(8), .BASE_ADDR(0), .POLL_INTERVAL(POLL_INTERVAL), .MAX_POLLS(MAX_POLLS)
    ) u_dut (
        .clk(clk), .rst(rst), .refresh(refresh),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .idcode(idcode), .die_serial(die_serial), .usercode(usercode),
        .info_valid(info_valid), .busy(busy), .error(error), .error_code(error_code)
    );

    apb_devinfo_reader #(
        .ADDR_WIDTH(8), .BASE_ADDR(0), .POLL_INTERVAL(POLL_INTERVAL), .MAX_POLLS(MAX_POLLS_B)
    ) u_dut_b (
        .clk(clk), .rst(rst), .refresh(1'b0),
        .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite), .paddr(b_paddr), .pwdata(b_pwdata),
        .pready(b_pready), .prdata(32'h0), .pslverr(1'b0),
        .idcode(b_idcode), .die_serial(b_die_serial), .usercode(b_usercode),
        .info_valid(b_info_valid), .busy(b_busy), .error(b_error), .error_code(b_error_code)
    );

    assign b_pready = b_psel & b_penable;

    always @(posedge clk) begin
        if (rst) b_reads <= 0;
        else if (b_psel && b_penable && !b_pwrite && b_paddr == 8'h00) b_reads <= b_reads + 1;
    end

    // ------------------------------------------------------- completer model
    assign pready  = psel && penable && (acc_cnt >= wait_states);
    assign pslverr = pready && (int'(paddr) == err_addr);

    always_comb begin
        prdata = 32'h0;
        case (paddr)
            8'h00:   prdata = {30'h0, (status_seen < bad_limit) ? bad_status : 2'b11};
            8'h04:   prdata = reg_idcode;
            8'h0c:   prdata = reg_ser0;
            8'h10:   prdata = reg_ser1;
            8'h14:   prdata = reg_user;
            8'h18:   prdata = reg_scratch;
            default: prdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (pready && !pwrite && paddr == 8'h00) status_seen <= status_seen + 1;
    end

    // ------------------------------------------------------------- utilities
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic w = 1'b0, input logic [31:0] d = 32'h0);
        exp_arr[exp_wr].addr = a;
        exp_arr[exp_wr].wr   = w;
        exp_arr[exp_wr].data = d;
        exp_wr++;
    endtask

    task automatic push_reads(input int status_reads);
        for (int i = 0; i < status_reads; i++) push(8'h00);
        push(8'h04);
        push(8'h0c);
        push(8'h10);
        push(8'h14);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    // ------------------------------------------- behavioural model + compare
    initial begin : compare_proc
        xfer_t e;
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("idcode", idcode, m_idcode);
                chk("die_serial", die_serial, m_serial);
                chk("usercode", usercode, m_user);
                chk("info_valid", info_valid, mstate == 1);
                chk("busy", busy, mstate == 0);
                chk("error", error, mstate == 2);
                chk("error_code", error_code, mcode);
                chk("penable_without_psel", penable & ~psel, 1'b0);
                if (psel && !penable) begin
                    chk("idle_gap", idle >= 1, 1'b1);
                    if (last_bad) chk("poll_spacing", idle >= POLL_INTERVAL, 1'b1);
                    idle = 0;
                end else if (!psel) begin
                    idle++;
                end
                if (psel && penable && pready) begin
                    if (exp_rd >= exp_wr) begin
                        chk("transfer_count", exp_rd + 1, exp_wr);
                    end else begin
                        e = exp_arr[exp_rd];
                        exp_rd++;
                        chk("paddr", paddr, e.addr);
                        chk("pwrite", pwrite, e.wr);
                        chk("pwdata", pwdata, e.data);
                        last_bad = 0;
                        if (pslverr) begin
                            mstate = 2;
                            mcode  = 2'd1;
                        end else if (!e.wr) begin
                            case (e.addr)
                                8'h00: if (prdata[1:0] != 2'b11) begin
                                    last_bad = 1;
                                    mpolls++;
                                    if (mpolls >= MAX_POLLS) begin
                                        mstate = 2;
                                        mcode  = 2'd2;
                                    end
                                end
                                8'h04: m_idcode = prdata;
                                8'h0c: m_serial[63:32] = prdata;
                                8'h10: m_serial[31:0] = prdata;
                                8'h14: begin
                                    m_user = prdata;
                                    mstate = 1;
                                end
                                8'h18: if (prdata != 32'hA5A55A5A) begin
                                    mstate = 2;
                                    mcode  = 2'd3;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                if (refresh && mstate != 0) begin
                    mstate = 0;
                    mcode  = 2'd0;
                    mpolls = 0;
                end
            end
            if (rst) begin
                m_idcode = 32'h0;
                m_serial = 64'h0;
                m_user   = 32'h0;
                mstate   = 0;
                mcode    = 2'd0;
                mpolls   = 0;
                last_bad = 0;
                exp_rd   = exp_wr;
                checking = 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- stimulus
    initial begin
        int n;
        rst         = 1'b1;
        refresh     = 1'b0;
        wait_states = 0;
        err_addr    = -1;
        bad_limit   = 0;
        status_seen = 0;
        acc_cnt     = 0;
        bad_status  = 2'b01;
        reg_idcode  = 32'h0362D093;
        reg_ser0    = 32'h000ADBEE;
        reg_ser1    = 32'hFC0DEF00;
        reg_user    = 32'h12345678;
        reg_scratch = 32'h5555AAAA;
        tick(2);

        // reset values
        chk("rst psel", psel, 1'b0);
        chk("rst penable", penable, 1'b0);
        chk("rst pwrite", pwrite, 1'b0);
        chk("rst paddr", paddr, 8'h00);
        chk("rst pwdata", pwdata, 32'h0);
        chk("rst busy", busy, 1'b1);
        chk("rst info_valid", info_valid, 1'b0);
        chk("rst error", error, 1'b0);
        chk("rst error_code", error_code, 2'd0);
        chk("rst idcode", idcode, 32'h0);
        chk("rst die_serial", die_serial, 64'h0);
        chk("rst usercode", usercode, 32'h0);
        rst = 1'b0;

`ifdef DEVINFO_READER_SELFTEST_EN
        // scratch readback differs: one write, one read, then error 3
        push(8'h18, 1'b1, 32'hA5A55A5A);
        push(8'h18);
        wait_idle(200, "st1 finished");
        chk("st1 error", error, 1'b1);
        chk("st1 error_code", error_code, 2'd3);
        chk("st1 info_valid", info_valid, 1'b0);
        tick(20);
        chk("st1 transfers", exp_rd, exp_wr);

        // scratch readback matches: full sequence follows
        reg_scratch = 32'hA5A55A5A;
        push(8'h18, 1'b1, 32'hA5A55A5A);
        push(8'h18);
        push_reads(1);
        pulse_refresh();
        wait_idle(300, "st2 finished");
        chk("st2 info_valid", info_valid, 1'b1);
        chk("st2 idcode", idcode, 32'h0362D093);
        chk("st2 usercode", usercode, 32'h12345678);
        chk("st2 transfers", exp_rd, exp_wr);
`else
        // 1: status ready at once, zero wait states
        push_reads(1);
        wait_idle(200, "s1 finished");
        chk("s1 info_valid", info_valid, 1'b1);
        chk("s1 idcode", idcode, 32'h0362D093);
        chk("s1 die_serial", die_serial, 64'h000ADBEE_FC0DEF00);
        chk("s1 usercode", usercode, 32'h12345678);
        tick(10);
        chk("s1 transfers", exp_rd, exp_wr);

        // stuck STATUS on the second instance: three polls, then timeout
        n = 0;
        while (b_error !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("b error", b_error, 1'b1);
        chk("b error_code", b_error_code, 2'd2);
        chk("b status reads", b_reads, MAX_POLLS_B);
        chk("b info_valid", b_info_valid, 1'b0);

        // 2: three not-ready polls, wait states, refresh while busy ignored
        reg_idcode = 32'h13631093;
        reg_ser0   = 32'h11112222;
        reg_ser1   = 32'h33334444;
        reg_user   = 32'hCAFEF00D;
        bad_limit  = status_seen + 3;
        wait_states = 2;
        push_reads(4);
        pulse_refresh();
        tick(6);
        pulse_refresh();
        wait_idle(500, "s2 finished");
        chk("s2 info_valid", info_valid, 1'b1);
        chk("s2 idcode", idcode, 32'h13631093);
        chk("s2 die_serial", die_serial, 64'h11112222_33334444);
        chk("s2 usercode", usercode, 32'hCAFEF00D);
        chk("s2 transfers", exp_rd, exp_wr);

        // 3: slverr on SERIAL_0, then recovery by refresh
        reg_idcode  = 32'hAAAA5555;
        err_addr    = 32'h0c;
        wait_states = 1;
        push(8'h00);
        push(8'h04);
        push(8'h0c);
        pulse_refresh();
        wait_idle(300, "s3 finished");
        chk("s3 error", error, 1'b1);
        chk("s3 error_code", error_code, 2'd1);
        chk("s3 info_valid", info_valid, 1'b0);
        chk("s3 idcode", idcode, 32'hAAAA5555);
        chk("s3 die_serial kept", die_serial, 64'h11112222_33334444);
        tick(20);
        chk("s3 transfers", exp_rd, exp_wr);
        err_addr = -1;
        reg_ser0 = 32'h5A5A0001;
        push_reads(1);
        pulse_refresh();
        wait_idle(300, "s3b finished");
        chk("s3b info_valid", info_valid, 1'b1);
        chk("s3b error", error, 1'b0);
        chk("s3b error_code", error_code, 2'd0);
        chk("s3b die_serial", die_serial, 64'h5A5A0001_33334444);

        // 4: reset in the middle of a stalled ACCESS
        wait_states = 5;
        pulse_refresh();
        n = 0;
        while (!(psel && penable) && n < 30) begin
            tick();
            n++;
        end
        chk("s4 in access", psel & penable, 1'b1);
        tick(2);
        rst = 1'b1;
        tick();
        chk("s4 psel", psel, 1'b0);
        chk("s4 penable", penable, 1'b0);
        chk("s4 paddr", paddr, 8'h00);
        chk("s4 busy", busy, 1'b1);
        chk("s4 info_valid", info_valid, 1'b0);
        chk("s4 idcode", idcode, 32'h0);
        chk("s4 die_serial", die_serial, 64'h0);
        chk("s4 usercode", usercode, 32'h0);
        rst = 1'b0;
        push_reads(1);
        wait_idle(300, "s4 finished");
        chk("s4 restart info_valid", info_valid, 1'b1);
        chk("s4 restart idcode", idcode, 32'hAAAA5555);
        chk("s4 restart die_serial", die_serial, 64'h5A5A0001_33334444);
        chk("s4 restart usercode", usercode, 32'hCAFEF00D);
        chk("s4 transfers", exp_rd, exp_wr);
`endif
        tick(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
